// File: rtl/hyper_tape_pkg.sv
// Register map, status/ctrl bit positions and RX entry layout for hyper_tape_port.
// Pure definitions; no logic, no latency, no backpressure.
package hyper_tape_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_TX_FULL     = 1;
  localparam int STAT_EOF         = 2;
  localparam int STAT_TX_OVF      = 3;
  localparam int STAT_RX_UNF      = 4;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_ERR = 1;

  localparam logic [7:0] UNDERFLOW_DAT = 8'hFF;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_ent_t;

  function automatic logic [7:0] status_byte(input logic rx_nonempty, input logic tx_full,
                                             input logic eof, input logic tx_ovf,
                                             input logic rx_unf);
    logic [7:0] s;
    s                   = 8'h00;
    s[STAT_RX_NONEMPTY] = rx_nonempty;
    s[STAT_TX_FULL]     = tx_full;
    s[STAT_EOF]         = eof;
    s[STAT_TX_OVF]      = tx_ovf;
    s[STAT_RX_UNF]      = rx_unf;
    return s;
  endfunction

endpackage

// File: rtl/hyper_tape_port_byte_fifo.sv
// Generic FIFO, dout = head combinationally (0 when empty); push visible next cycle.
// Backpressure: push ignored when full, pop ignored when empty, flush beats both.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gate the head so an empty FIFO never leaks uninitialised storage.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hyper_tape_port.sv
// CPU byte port bridging ROM load/save routines to host RX/TX FIFOs; reads return 1 clk later.
// Backpressure: rx_ready = RX not full, tx_valid = TX not empty; CPU overrun/underrun set sticky flags.
module hyper_tape_port
  import hyper_tape_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h2100,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        enable,
  output logic [7:0]  q,
  output logic        hit,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic       sel, off, rd_act, wr_act;
  logic       prev_rd_act, prev_wr_act, pop_pend;
  logic       rd_rise, rd_fall, wr_rise;
  logic       data_wr, ctrl_wr, flush, clr_err;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic       tx_pop, tx_full, tx_empty;
  logic       eof, tx_ovf, rx_unf;
  rx_ent_t    rx_din, rx_head;
  logic [7:0] status, rd_mux;

  assign sel    = enable && (a[15:1] == BASE_ADDR[15:1]);
  assign off    = a[0];
  assign rd_act = sel && !rd_n;
  assign wr_act = sel && !wr_n;

  // Edge detection makes a held strobe count as a single access.
  assign rd_rise = rd_act && !prev_rd_act;
  assign rd_fall = prev_rd_act && !rd_act;
  assign wr_rise = wr_act && !prev_wr_act;

  assign data_wr = wr_rise && (off == REG_DATA);
  assign ctrl_wr = wr_rise && (off == REG_STAT);
  assign flush   = ctrl_wr && d[CTRL_FLUSH];
  assign clr_err = ctrl_wr && d[CTRL_CLR_ERR];

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_fall && pop_pend;
  assign rx_din   = '{last: rx_last, data: rx_data};

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  assign status = status_byte(!rx_empty, tx_full, eof, tx_ovf, rx_unf);
  assign rd_mux = (off == REG_STAT) ? status :
                  (rx_empty ? UNDERFLOW_DAT : rx_head.data);

  byte_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (flush),
    .din     (rx_din),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_wr),
    .pop     (tx_pop),
    .flush   (flush),
    .din     (d),
    .dout    (tx_data),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // q is captured once at access start and held, so the CPU sees a stable byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_rd_act <= 1'b0;
      prev_wr_act <= 1'b0;
      pop_pend    <= 1'b0;
      q           <= 8'h00;
      hit         <= 1'b0;
    end else begin
      prev_rd_act <= rd_act;
      prev_wr_act <= wr_act;
      if (rd_rise) begin
        q        <= rd_mux;
        hit      <= 1'b1;
        pop_pend <= (off == REG_DATA) && !rx_empty;
      end else if (!rd_act) begin
        q        <= 8'h00;
        hit      <= 1'b0;
        pop_pend <= 1'b0;
      end
      if (flush) pop_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eof    <= 1'b0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (flush)
        eof <= 1'b0;
      else if (rx_pop && !rx_empty && rx_head.last)
        eof <= 1'b1;

      if (data_wr && tx_full)
        tx_ovf <= 1'b1;
      else if (clr_err)
        tx_ovf <= 1'b0;

      if (rd_rise && (off == REG_DATA) && rx_empty)
        rx_unf <= 1'b1;
      else if (clr_err)
        rx_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hyper_tape_port.sv
// Scoreboarded bench for hyper_tape_port: CPU reads and host TX bytes are queued on issue
// and checked by a negedge monitor as the DUT presents them.
module tb_hyper_tape_port;

  localparam logic [15:0] BASE = 16'h2100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  q;
  logic        hit;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_last = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] rdq[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  hyper_tape_port #(.BASE_ADDR(BASE), .DEPTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a        (a),
    .d        (d),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .enable   (enable),
    .q        (q),
    .hit      (hit),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_last  (rx_last),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: first cycle of hit pops the read scoreboard, later cycles check stability.
  logic       prev_hit = 1'b0;
  logic [7:0] held_exp = 8'h00;
  always @(negedge clk) begin
    if (hit && !prev_hit) begin
      if (rdq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got q=%h with no read pending", q);
      end else begin
        held_exp = rdq.pop_front();
        chk("read_q", q, held_exp);
      end
    end else if (hit) begin
      chk("read_hold", q, held_exp);
    end else if (prev_hit) begin
      chk("q_zero_after_read", q, 8'h00);
    end
    prev_hit = hit;

    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx: got tx_data=%h with nothing expected", tx_data);
      end else begin
        chk("tx_data", tx_data, txq.pop_front());
      end
    end
  end

  task automatic cpu_read(input logic off, input int hold, input logic [7:0] exp);
    rdq.push_back(exp);
    @(posedge clk); #1;
    a    = BASE + {15'd0, off};
    rd_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1 rd_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic off, input logic [7:0] val);
    @(posedge clk); #1;
    a    = BASE + {15'd0, off};
    d    = val;
    wr_n = 1'b0;
    @(posedge clk); #1;
    wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic host_push(input logic [7:0] val, input logic last);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    rx_data  = val;
    rx_last  = last;
    rx_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL host_push_timeout: byte %h never accepted", val);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_hit", 8'(hit), 8'h00);
    chk("rst_rx_ready", 8'(rx_ready), 8'h01);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    reset_n = 1'b1;
    cpu_read(1'b1, 1, 8'h00);

    // Held read strobes pop exactly once; last byte sets eof
    host_push(8'h3A, 1'b0);
    host_push(8'h55, 1'b1);
    cpu_read(1'b0, 3, 8'h3A);
    cpu_read(1'b0, 3, 8'h55);
    cpu_read(1'b1, 1, 8'h04);
    cpu_write(1'b1, 8'h01);
    cpu_read(1'b1, 1, 8'h00);

    // RX fills at 16; 17th byte waits for one CPU pop
    for (int i = 0; i < 16; i++) host_push(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    chk("rx_ready_full", 8'(rx_ready), 8'h00);
    fork
      host_push(8'h20, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("rx_ready_still_full", 8'(rx_ready), 8'h00);
        cpu_read(1'b0, 2, 8'h10);
      end
    join
    for (int i = 1; i <= 16; i++) cpu_read(1'b0, 1, 8'h10 + 8'(i));
    cpu_read(1'b1, 1, 8'h00);

    // Underflow read and error clear
    cpu_read(1'b0, 1, 8'hFF);
    cpu_read(1'b1, 1, 8'h10);
    cpu_write(1'b1, 8'h02);
    cpu_read(1'b1, 1, 8'h00);

    // TX overflow, then drain in order
    tx_ready = 1'b0;
    cpu_write(1'b0, 8'hA0);
    chk("tx_valid_after_write", 8'(tx_valid), 8'h01);
    chk("tx_head_after_write", tx_data, 8'hA0);
    txq.push_back(8'hA0);
    for (int i = 1; i < 17; i++) begin
      cpu_write(1'b0, 8'hA0 + 8'(i));
      if (i < 16) txq.push_back(8'hA0 + 8'(i));
    end
    cpu_read(1'b1, 1, 8'h0A);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 200 && txq.size() != 0; i++) @(posedge clk);
    tests++;
    if (txq.size() != 0) begin
      fails++;
      $display("FAIL tx_drain_timeout: %0d bytes left, expected 0", txq.size());
    end
    @(negedge clk);
    chk("tx_valid_drained", 8'(tx_valid), 8'h00);
    cpu_write(1'b1, 8'h02);
    cpu_read(1'b1, 1, 8'h00);

    // Reset in the middle of a DATA read
    host_push(8'h77, 1'b0);
    rdq.push_back(8'h77);
    @(posedge clk); #1;
    a    = BASE;
    rd_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_hit", 8'(hit), 8'h00);
    chk("arst_q", q, 8'h00);
    chk("arst_rx_ready", 8'(rx_ready), 8'h01);
    rd_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cpu_read(1'b1, 1, 8'h00);
    host_push(8'h42, 1'b0);
    cpu_read(1'b0, 1, 8'h42);
    cpu_read(1'b1, 1, 8'h00);

    for (int i = 0; i < 20 && rdq.size() != 0; i++) @(posedge clk);
    tests++;
    if (rdq.size() != 0) begin
      fails++;
      $display("FAIL read_scoreboard: %0d reads never seen, expected 0", rdq.size());
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hyper_tape_port.md
# hyper_tape_port

Memory-mapped byte port that the patched hyperload/hypersave ROM routines talk to instead of bit-banging the cassette line. It sits on the CPU bus next to the ROM patch overlay. It buffers incoming tape bytes from the host/SD loader in an RX FIFO for the load routine. It buffers bytes written by the save routine in a TX FIFO that drains to the host.

## Interface
Parameters:
- BASE_ADDR, 16'h2100: port base address; must be even; window is BASE_ADDR..BASE_ADDR+1.
- DEPTH, 16: entries per FIFO; must be a power of two, at least 2.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- a, input, 16: CPU address.
- d, input, 8: CPU write data.
- rd_n, input, 1: CPU read strobe, active-low, synchronous to clk.
- wr_n, input, 1: CPU write strobe, active-low, synchronous to clk.
- enable, input, 1: port active; driven by the same override signal as the ROM patch.
- q, output, 8: registered read data.
- hit, output, 1: registered; high while q is valid for the CPU data-bus mux.
- rx_data, input, 8: host byte.
- rx_valid, input, 1: host byte valid.
- rx_last, input, 1: marks the final byte of the tape image.
- rx_ready, output, 1: RX FIFO can accept a byte.
- tx_data, output, 8: saved byte to host.
- tx_valid, output, 1: TX FIFO non-empty.
- tx_ready, input, 1: host accepts the byte.

## Operation
- Select: sel = enable && a[15:1] == BASE_ADDR[15:1].
- rd_act = sel && !rd_n.
- wr_act = sel && !wr_n.
- Offset 0, read DATA: returns the RX head byte.
- Offset 0, write DATA: pushes d into the TX FIFO.
- Offset 1, read STATUS:
  - bit0 rx_nonempty
  - bit1 tx_full
  - bit2 eof
  - bit3 tx_overflow
  - bit4 rx_underflow
  - bits7:5 are 0
- Offset 1, write CTRL:
  - bit0 = 1 flushes both FIFOs and clears eof.
  - bit1 = 1 clears both sticky error bits.
  - Both bits may be set in one write.
- Each RX entry stores 9 bits: {last, data}. A push happens when rx_valid && rx_ready; the host holds data until accepted.
- Popping the RX entry with last=1 sets eof. eof stays set until a CTRL flush.
- DATA read with the RX FIFO empty:
  - q = 8'hFF
  - no pop
  - rx_underflow set
- DATA write with the TX FIFO full:
  - byte dropped
  - tx_overflow set
- One CPU access produces at most one side effect, however many cycles the strobe is held:
  - Pop happens on the cycle rd_act falls (prev_rd_act && !rd_act); the byte stays stable for the whole access.
  - Push or CTRL action happens on the cycle wr_act rises.
- Dropping enable mid-access ends the access. A read completes its pop on that cycle.
- TX drain: a pop happens when tx_valid && tx_ready.

## Timing
- Reset state:
  - q = 8'h00, hit = 0
  - both FIFOs empty, so rx_ready = 1, tx_valid = 0, tx_data = 8'h00
  - eof = 0, sticky bits = 0
- Read latency is 1 clk: q and hit register from the rd_act cycle and stay valid while rd_act holds. q and hit are 0 the cycle after rd_act drops.
- rx_ready = !rx_full, combinational from the registered count.
- tx_valid = !tx_empty, combinational from the registered count.
- tx_data = TX head, combinational from storage.
- FIFO counts are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Simultaneous push and pop on the same FIFO:
  - Non-full, non-empty: count unchanged, both take effect.
  - Full: push is blocked (ready low) and the pop proceeds.
  - Empty: pop does not occur and the push proceeds.
- A CTRL flush wins over a same-cycle host push or host pop; that host handshake is discarded.
- A byte written to DATA in cycle N is visible on tx_data/tx_valid in cycle N+1.
- An RX byte accepted in cycle N gives STATUS bit0 = 1 from a read issued in cycle N+1.

## Structure
- Package hyper_tape_pkg holds:
  - register offsets REG_DATA = 0, REG_STAT = 1
  - STATUS bit indices and CTRL bit indices
  - the underflow read value 8'hFF
- Sub-module byte_fifo, parameterised by WIDTH and DEPTH:
  - ports: push, pop, flush, din, dout, full, empty
  - instantiated as RX (WIDTH 9) and TX (WIDTH 8)
- The top level holds decode, strobe edge detection, the status and sticky registers, and the q mux.

## Test plan
- Reset, then read STATUS -> q = 8'h00; rx_ready = 1; tx_valid = 0.
- Host pushes 8'h3A, 8'h55 (last=1); CPU holds rd_n low for 3 clk at BASE+0, twice:
  - First access: q = 8'h3A throughout, exactly one pop.
  - Second access: q = 8'h55.
  - STATUS afterwards = 8'h04.
- Host pushes 17 bytes with DEPTH=16 -> rx_ready drops after 16; the 17th is accepted only after one CPU pop.
- Read DATA with RX empty -> q = 8'hFF, STATUS = 8'h10. CTRL write 8'h02 -> STATUS = 8'h00.
- tx_ready = 0; CPU writes 17 bytes -> STATUS = 8'h0A. Release tx_ready -> 16 bytes drain in order.
- Assert reset_n low mid-read -> hit and q go to 0 immediately; FIFOs empty; no pop after release.
